// File: rtl/l1_cmd_scheduler.sv
// Front-end command scheduler for the split L1 model: arbitrates CPU trace and L2 snoop
// commands, dispatches them as req/ack transactions to dCache/iCache and keeps statistics.
module l1_cmd_scheduler #(
  parameter int ADDRESS_BITS   = 32,
  parameter int OFFSET_BITS    = 6,
  parameter int INDEX_BITS     = 4,
  parameter int SNP_STREAK_MAX = 2,
  parameter int STAT_W         = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cpu_valid,
  output logic                    cpu_ready,
  input  logic [3:0]              cpu_cmd,
  input  logic [ADDRESS_BITS-1:0] cpu_addr,
  input  logic                    snp_valid,
  output logic                    snp_ready,
  input  logic [3:0]              snp_cmd,
  input  logic [ADDRESS_BITS-1:0] snp_addr,
  output logic                    dc_req,
  output logic [2:0]              dc_op,
  output logic [ADDRESS_BITS-1:0] dc_addr,
  input  logic                    dc_ack,
  input  logic                    dc_hit,
  output logic                    ic_req,
  output logic [2:0]              ic_op,
  output logic [ADDRESS_BITS-1:0] ic_addr,
  input  logic                    ic_ack,
  input  logic                    ic_hit,
  output logic [STAT_W-1:0]       stat_read,
  output logic [STAT_W-1:0]       stat_write,
  output logic [STAT_W-1:0]       stat_fetch,
  output logic [STAT_W-1:0]       stat_hit,
  output logic [STAT_W-1:0]       stat_miss,
  output logic                    print_pulse,
  output logic                    err_cmd,
  output logic                    busy
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPATCH = 2'd1;
  localparam logic [1:0] ST_CLEAR    = 2'd2;
  localparam logic [1:0] ST_PRINT    = 2'd3;

  localparam logic [3:0] CMD_READ    = 4'd0;
  localparam logic [3:0] CMD_WRITE   = 4'd1;
  localparam logic [3:0] CMD_IFETCH  = 4'd2;
  localparam logic [3:0] CMD_INVAL   = 4'd3;
  localparam logic [3:0] CMD_DATA_RQ = 4'd4;
  localparam logic [3:0] CMD_CLR     = 4'd8;
  localparam logic [3:0] CMD_PRINT   = 4'd9;

  localparam logic [2:0] OP_RD      = 3'd0;
  localparam logic [2:0] OP_WR      = 3'd1;
  localparam logic [2:0] OP_FETCH   = 3'd2;
  localparam logic [2:0] OP_INVAL   = 3'd3;
  localparam logic [2:0] OP_DATA_RQ = 3'd4;
  localparam logic [2:0] OP_CLR_SET = 3'd5;

  localparam int             SW         = $clog2(SNP_STREAK_MAX + 1);
  localparam logic [SW-1:0]  STREAK_MAX = SW'(SNP_STREAK_MAX);

  logic [1:0]              state_q, state_d;
  logic [SW-1:0]           streak_q, streak_d;
  logic [INDEX_BITS-1:0]   idx_q, idx_d;
  logic                    gap_q, gap_d;
  logic                    dc_seen_q, dc_seen_d;
  logic                    ic_seen_q, ic_seen_d;
  logic                    dc_req_q, dc_req_d, ic_req_q, ic_req_d;
  logic [2:0]              dc_op_q, dc_op_d, ic_op_q, ic_op_d;
  logic [ADDRESS_BITS-1:0] dc_addr_q, dc_addr_d, ic_addr_q, ic_addr_d;
  logic [STAT_W-1:0]       rd_q, rd_d, wr_q, wr_d, fe_q, fe_d, hit_q, hit_d, miss_q, miss_d;
  logic                    print_q, print_d, err_q, err_d, busy_q, busy_d;
  logic                    grant_snp, grant_cpu, dc_both, ic_both;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
    return (c == '1) ? c : c + STAT_W'(1);
  endfunction

  function automatic logic [ADDRESS_BITS-1:0] clr_addr(input logic [INDEX_BITS-1:0] idx);
    logic [ADDRESS_BITS-1:0] a;
    a = '0;
    a[OFFSET_BITS +: INDEX_BITS] = idx;
    return a;
  endfunction

  // Snoops win unless the CPU has already been passed over SNP_STREAK_MAX times in a row.
  assign grant_snp = (state_q == ST_IDLE) && snp_valid && (!cpu_valid || (streak_q < STREAK_MAX));
  assign grant_cpu = (state_q == ST_IDLE) && cpu_valid && !grant_snp;
  assign cpu_ready = grant_cpu;
  assign snp_ready = grant_snp;

  assign dc_both = dc_seen_q | dc_ack;
  assign ic_both = ic_seen_q | ic_ack;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    streak_d  = streak_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    dc_seen_d = dc_seen_q;
    ic_seen_d = ic_seen_q;
    dc_req_d  = dc_req_q;
    ic_req_d  = ic_req_q;
    dc_op_d   = dc_op_q;
    ic_op_d   = ic_op_q;
    dc_addr_d = dc_addr_q;
    ic_addr_d = ic_addr_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    fe_d      = fe_q;
    hit_d     = hit_q;
    miss_d    = miss_q;
    print_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_snp) begin
          if (cpu_valid) streak_d = streak_q + SW'(1);
          if (snp_cmd == CMD_INVAL || snp_cmd == CMD_DATA_RQ) begin
            state_d   = ST_DISPATCH;
            dc_req_d  = 1'b1;
            dc_op_d   = (snp_cmd == CMD_INVAL) ? OP_INVAL : OP_DATA_RQ;
            dc_addr_d = snp_addr;
          end else begin
            err_d = 1'b1;
          end
        end else if (grant_cpu) begin
          streak_d = '0;
          case (cpu_cmd)
            CMD_READ, CMD_WRITE: begin
              state_d   = ST_DISPATCH;
              dc_req_d  = 1'b1;
              dc_op_d   = (cpu_cmd == CMD_READ) ? OP_RD : OP_WR;
              dc_addr_d = cpu_addr;
              if (cpu_cmd == CMD_READ) rd_d = sat_inc(rd_q);
              else                     wr_d = sat_inc(wr_q);
            end
            CMD_IFETCH: begin
              state_d   = ST_DISPATCH;
              ic_req_d  = 1'b1;
              ic_op_d   = OP_FETCH;
              ic_addr_d = cpu_addr;
              fe_d      = sat_inc(fe_q);
            end
            CMD_CLR: begin
              state_d   = ST_CLEAR;
              idx_d     = '0;
              gap_d     = 1'b0;
              dc_seen_d = 1'b0;
              ic_seen_d = 1'b0;
              dc_req_d  = 1'b1;
              ic_req_d  = 1'b1;
              dc_op_d   = OP_CLR_SET;
              ic_op_d   = OP_CLR_SET;
              dc_addr_d = clr_addr('0);
              ic_addr_d = clr_addr('0);
              rd_d      = '0;
              wr_d      = '0;
              fe_d      = '0;
              hit_d     = '0;
              miss_d    = '0;
            end
            CMD_PRINT: begin
              state_d = ST_PRINT;
              print_d = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_DISPATCH: begin
        // Only one side is requested here, so the other side's ack is ignored.
        if (dc_req_q && dc_ack) begin
          dc_req_d = 1'b0;
          state_d  = ST_IDLE;
          if (dc_op_q == OP_RD || dc_op_q == OP_WR) begin
            if (dc_hit) hit_d  = sat_inc(hit_q);
            else        miss_d = sat_inc(miss_q);
          end
        end else if (ic_req_q && ic_ack) begin
          ic_req_d = 1'b0;
          state_d  = ST_IDLE;
          if (ic_op_q == OP_FETCH) begin
            if (ic_hit) hit_d  = sat_inc(hit_q);
            else        miss_d = sat_inc(miss_q);
          end
        end
      end

      ST_CLEAR: begin
        if (gap_q) begin
          gap_d     = 1'b0;
          idx_d     = idx_q + INDEX_BITS'(1);
          dc_req_d  = 1'b1;
          ic_req_d  = 1'b1;
          dc_addr_d = clr_addr(idx_q + INDEX_BITS'(1));
          ic_addr_d = clr_addr(idx_q + INDEX_BITS'(1));
        end else if (dc_both && ic_both) begin
          dc_seen_d = 1'b0;
          ic_seen_d = 1'b0;
          dc_req_d  = 1'b0;
          ic_req_d  = 1'b0;
          if (idx_q == '1) state_d = ST_IDLE;
          else             gap_d   = 1'b1;
        end else begin
          dc_seen_d = dc_both;
          ic_seen_d = ic_both;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      streak_q  <= '0;
      idx_q     <= '0;
      gap_q     <= 1'b0;
      dc_seen_q <= 1'b0;
      ic_seen_q <= 1'b0;
      dc_req_q  <= 1'b0;
      ic_req_q  <= 1'b0;
      dc_op_q   <= '0;
      ic_op_q   <= '0;
      dc_addr_q <= '0;
      ic_addr_q <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      fe_q      <= '0;
      hit_q     <= '0;
      miss_q    <= '0;
      print_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      dc_seen_q <= dc_seen_d;
      ic_seen_q <= ic_seen_d;
      dc_req_q  <= dc_req_d;
      ic_req_q  <= ic_req_d;
      dc_op_q   <= dc_op_d;
      ic_op_q   <= ic_op_d;
      dc_addr_q <= dc_addr_d;
      ic_addr_q <= ic_addr_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      fe_q      <= fe_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      print_q   <= print_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign dc_req      = dc_req_q;
  assign ic_req      = ic_req_q;
  assign dc_op       = dc_op_q;
  assign ic_op       = ic_op_q;
  assign dc_addr     = dc_addr_q;
  assign ic_addr     = ic_addr_q;
  assign stat_read   = rd_q;
  assign stat_write  = wr_q;
  assign stat_fetch  = fe_q;
  assign stat_hit    = hit_q;
  assign stat_miss   = miss_q;
  assign print_pulse = print_q;
  assign err_cmd     = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_l1_cmd_scheduler.sv
// Directed bench for l1_cmd_scheduler built with STAT_W=4 so saturation is reachable;
// a small cache responder acks requests after a programmable number of cycles.
module tb_l1_cmd_scheduler;

  localparam int AB = 32;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_valid, cpu_ready, snp_valid, snp_ready;
  logic [3:0]    cpu_cmd, snp_cmd;
  logic [AB-1:0] cpu_addr, snp_addr;
  logic          dc_req, ic_req, dc_ack, ic_ack, dc_hit, ic_hit;
  logic [2:0]    dc_op, ic_op;
  logic [AB-1:0] dc_addr, ic_addr;
  logic [SW-1:0] stat_read, stat_write, stat_fetch, stat_hit, stat_miss;
  logic          print_pulse, err_cmd, busy;

  logic dc_ack_r, ic_ack_r, dc_ack_man, ic_ack_man, dc_hit_val, ic_hit_val;
  int   dc_lat, ic_lat, dc_wait, ic_wait;
  bit   dc_done, ic_done;
  int   n_checks = 0;
  int   n_pass   = 0;

  assign dc_ack = dc_ack_r | dc_ack_man;
  assign ic_ack = ic_ack_r | ic_ack_man;
  assign dc_hit = dc_hit_val;
  assign ic_hit = ic_hit_val;

  always #5 clk = ~clk;

  l1_cmd_scheduler #(
    .ADDRESS_BITS(AB), .OFFSET_BITS(6), .INDEX_BITS(4), .SNP_STREAK_MAX(2), .STAT_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_cmd(cpu_cmd), .cpu_addr(cpu_addr),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_cmd(snp_cmd), .snp_addr(snp_addr),
    .dc_req(dc_req), .dc_op(dc_op), .dc_addr(dc_addr), .dc_ack(dc_ack), .dc_hit(dc_hit),
    .ic_req(ic_req), .ic_op(ic_op), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_hit(ic_hit),
    .stat_read(stat_read), .stat_write(stat_write), .stat_fetch(stat_fetch),
    .stat_hit(stat_hit), .stat_miss(stat_miss),
    .print_pulse(print_pulse), .err_cmd(err_cmd), .busy(busy)
  );

  // Cache responder: acks a held request once, dc_lat/ic_lat cycles after it rises.
  initial begin
    dc_ack_r = 1'b0; ic_ack_r = 1'b0; dc_wait = 0; ic_wait = 0; dc_done = 1'b0; ic_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!dc_req) begin dc_wait = 0; dc_done = 1'b0; dc_ack_r = 1'b0; end
      else if (dc_done) dc_ack_r = 1'b0;
      else if (dc_wait == dc_lat) begin dc_ack_r = 1'b1; dc_done = 1'b1; end
      else begin dc_ack_r = 1'b0; dc_wait++; end
      if (!ic_req) begin ic_wait = 0; ic_done = 1'b0; ic_ack_r = 1'b0; end
      else if (ic_done) ic_ack_r = 1'b0;
      else if (ic_wait == ic_lat) begin ic_ack_r = 1'b1; ic_done = 1'b1; end
      else begin ic_ack_r = 1'b0; ic_wait++; end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin tick(); n++; end
    check("idle_reached", 32'(busy), 0);
  endtask

  // Presents a CPU command, waits (bounded) for its grant, returns 1 ns after the accept edge.
  task automatic cpu_accept(input logic [3:0] cmd, input logic [AB-1:0] addr);
    int n = 0;
    cpu_valid = 1'b1; cpu_cmd = cmd; cpu_addr = addr;
    #1;
    while (!cpu_ready && n < 20) begin tick(); #1; n++; end
    check("cpu_grant", 32'(cpu_ready), 1);
    tick();
    cpu_valid = 1'b0;
  endtask

  task automatic snp_accept(input logic [3:0] cmd, input logic [AB-1:0] addr);
    int n = 0;
    snp_valid = 1'b1; snp_cmd = cmd; snp_addr = addr;
    #1;
    while (!snp_ready && n < 20) begin tick(); #1; n++; end
    check("snp_grant", 32'(snp_ready), 1);
    tick();
    snp_valid = 1'b0;
  endtask

  initial begin
    int g[6];
    int k, n, high;
    bit both_seen, snp_leak, gap_idle;
    int exp_g[6] = '{1, 1, 2, 1, 1, 2};

    rst_n = 1'b0; cpu_valid = 1'b0; snp_valid = 1'b0; cpu_cmd = '0; snp_cmd = '0;
    cpu_addr = '0; snp_addr = '0; dc_ack_man = 1'b0; ic_ack_man = 1'b0;
    dc_hit_val = 1'b0; ic_hit_val = 1'b0; dc_lat = 0; ic_lat = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dc_req", 32'(dc_req), 0);
    check("rst_ic_req", 32'(ic_req), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_stat_read", 32'(stat_read), 0);
    check("rst_stat_hit", 32'(stat_hit), 0);
    rst_n = 1'b1;
    tick();

    // READ 0x1040 acked in its first req cycle as a miss.
    cpu_valid = 1'b1; cpu_cmd = 4'd0; cpu_addr = 32'h0000_1040;
    #1;
    check("read_cpu_ready", 32'(cpu_ready), 1);
    check("read_snp_ready", 32'(snp_ready), 0);
    tick();
    cpu_valid = 1'b0;
    check("read_dc_req", 32'(dc_req), 1);
    check("read_dc_op", 32'(dc_op), 0);
    check("read_dc_addr", dc_addr, 32'h0000_1040);
    check("read_ic_req", 32'(ic_req), 0);
    check("read_busy", 32'(busy), 1);
    check("read_stat_read", 32'(stat_read), 1);
    tick();
    check("read_done_req", 32'(dc_req), 0);
    check("read_done_busy", 32'(busy), 0);
    check("read_stat_miss", 32'(stat_miss), 1);
    check("read_stat_hit", 32'(stat_hit), 0);

    // WRITE presented right away: ready again two cycles after the READ accept; hits.
    dc_hit_val = 1'b1;
    cpu_valid = 1'b1; cpu_cmd = 4'd1; cpu_addr = 32'h0000_2000;
    #1;
    check("ready_n2", 32'(cpu_ready), 1);
    tick();
    cpu_valid = 1'b0;
    check("write_dc_op", 32'(dc_op), 1);
    check("write_dc_addr", dc_addr, 32'h0000_2000);
    check("write_stat_write", 32'(stat_write), 1);
    wait_idle();
    check("write_stat_hit", 32'(stat_hit), 1);

    // I_FETCH with a stray dc_ack held high: only the iCache ack counts.
    dc_ack_man = 1'b1; ic_lat = 1; ic_hit_val = 1'b1;
    cpu_accept(4'd2, 32'h0000_3000);
    check("fetch_ic_req", 32'(ic_req), 1);
    check("fetch_ic_op", 32'(ic_op), 2);
    check("fetch_ic_addr", ic_addr, 32'h0000_3000);
    check("fetch_dc_req", 32'(dc_req), 0);
    check("fetch_stat_fetch", 32'(stat_fetch), 1);
    wait_idle();
    dc_ack_man = 1'b0;
    check("fetch_stat_hit", 32'(stat_hit), 2);
    check("fetch_stat_miss", 32'(stat_miss), 1);

    // Lone snoop DATA_RQ goes to dCache; its hit ack leaves stat_hit alone.
    snp_accept(4'd4, 32'h0000_5000);
    check("snp_dc_req", 32'(dc_req), 1);
    check("snp_dc_op", 32'(dc_op), 4);
    check("snp_dc_addr", dc_addr, 32'h0000_5000);
    wait_idle();
    check("snp_stat_hit", 32'(stat_hit), 2);

    // Both ports valid continuously: expect S, S, C, S, S, C (1 = snoop, 2 = CPU).
    cpu_valid = 1'b1; cpu_cmd = 4'd0; cpu_addr = 32'h0000_0040;
    snp_valid = 1'b1; snp_cmd = 4'd3; snp_addr = 32'h0000_0080;
    for (int i = 0; i < 6; i++) g[i] = 0;
    k = 0; n = 0; both_seen = 1'b0;
    while (k < 6 && n < 40) begin
      #1;
      if (cpu_ready && snp_ready) both_seen = 1'b1;
      if (snp_ready) begin g[k] = 1; k++; end
      else if (cpu_ready) begin g[k] = 2; k++; end
      tick();
      n++;
    end
    cpu_valid = 1'b0; snp_valid = 1'b0;
    for (int i = 0; i < 6; i++) check($sformatf("grant_%0d", i), 32'(g[i]), 32'(exp_g[i]));
    check("grant_exclusive", 32'(both_seen), 0);
    wait_idle();
    check("arb_stat_read", 32'(stat_read), 3);
    check("arb_stat_hit", 32'(stat_hit), 4);

    // Illegal CPU and snoop commands, then PRINT.
    cpu_accept(4'd3, 32'h0);
    check("ill_err_cmd", 32'(err_cmd), 1);
    check("ill_dc_req", 32'(dc_req), 0);
    check("ill_ic_req", 32'(ic_req), 0);
    check("ill_busy", 32'(busy), 0);
    tick();
    check("ill_err_drop", 32'(err_cmd), 0);
    snp_accept(4'd7, 32'h0);
    check("ill_snp_err", 32'(err_cmd), 1);
    check("ill_snp_dc_req", 32'(dc_req), 0);
    tick();
    check("ill_snp_err_drop", 32'(err_cmd), 0);
    cpu_accept(4'd9, 32'h0);
    check("print_pulse", 32'(print_pulse), 1);
    check("print_busy", 32'(busy), 1);
    check("print_err", 32'(err_cmd), 0);
    tick();
    check("print_pulse_drop", 32'(print_pulse), 0);
    check("print_busy_drop", 32'(busy), 0);
    check("print_stat_read", 32'(stat_read), 3);

    // Acks with nothing outstanding are ignored.
    dc_ack_man = 1'b1; ic_ack_man = 1'b1;
    tick(); tick();
    dc_ack_man = 1'b0; ic_ack_man = 1'b0;
    check("spur_stat_hit", 32'(stat_hit), 4);
    check("spur_stat_miss", 32'(stat_miss), 1);

    // Saturation: 11 more hits bring stat_hit to 15, then it must hold.
    dc_hit_val = 1'b1;
    for (int i = 0; i < 11; i++) begin
      cpu_accept(4'd0, 32'h0000_0100);
      wait_idle();
    end
    check("sat_hit_15", 32'(stat_hit), 15);
    check("sat_read_14", 32'(stat_read), 14);
    cpu_accept(4'd0, 32'h0000_0100);
    wait_idle();
    check("sat_hit_hold", 32'(stat_hit), 15);
    check("sat_read_15", 32'(stat_read), 15);
    dc_hit_val = 1'b0;
    cpu_accept(4'd0, 32'h0000_0100);
    wait_idle();
    check("sat_read_hold", 32'(stat_read), 15);
    check("sat_miss_2", 32'(stat_miss), 2);

    // CLR with iCache acking 3 cycles after dCache; snoops held off throughout.
    dc_lat = 0; ic_lat = 3;
    cpu_accept(4'd8, 32'h0);
    snp_valid = 1'b1; snp_cmd = 4'd3; snp_addr = 32'h0;
    check("clr_stat_read", 32'(stat_read), 0);
    check("clr_stat_write", 32'(stat_write), 0);
    check("clr_stat_fetch", 32'(stat_fetch), 0);
    check("clr_stat_hit", 32'(stat_hit), 0);
    check("clr_stat_miss", 32'(stat_miss), 0);
    check("clr_dc_op", 32'(dc_op), 5);
    check("clr_ic_op", 32'(ic_op), 5);
    snp_leak = 1'b0; gap_idle = 1'b0;
    for (int idx = 0; idx < 16; idx++) begin
      n = 0;
      while (!(dc_req && ic_req) && n < 10) begin tick(); n++; end
      check($sformatf("clr_dc_addr_%0d", idx), dc_addr, 32'(idx << 6));
      check($sformatf("clr_ic_addr_%0d", idx), ic_addr, 32'(idx << 6));
      if (idx == 14) snp_valid = 1'b0;
      high = 0;
      while (dc_req && ic_req && high < 20) begin
        if (snp_ready) snp_leak = 1'b1;
        high++;
        tick();
      end
      check($sformatf("clr_held_%0d", idx), 32'(high), 4);
      if (idx < 15 && !busy) gap_idle = 1'b1;
    end
    check("clr_snp_blocked", 32'(snp_leak), 0);
    check("clr_gap_busy", 32'(gap_idle), 0);
    check("clr_end_busy", 32'(busy), 0);
    check("clr_end_dc_req", 32'(dc_req), 0);
    check("clr_end_ic_req", 32'(ic_req), 0);
    check("clr_end_stat_hit", 32'(stat_hit), 0);

    // Reset mid-DISPATCH drops req at once and clears the counters.
    dc_lat = 10;
    cpu_accept(4'd0, 32'h0000_7000);
    check("mid_dc_req", 32'(dc_req), 1);
    check("mid_stat_read", 32'(stat_read), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dc_req", 32'(dc_req), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_stat_read", 32'(stat_read), 0);
    tick();
    rst_n = 1'b1;
    dc_lat = 0;
    tick();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_dc_req", 32'(dc_req), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
